// File: rtl/iir_decim_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iir_decim_fifo
// Purpose  : Boxcar decimator (factor 2**DECIM_LOG2) for the IIR filter
//            output, followed by a first-word-fall-through FIFO that presents
//            the decimated samples on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module iir_decim_fifo #(
    parameter int DATA_W     = 24,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic                          in_valid,
    output logic signed [DATA_W-1:0]      out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow
);

    localparam int c_ACC_W  = DATA_W + DECIM_LOG2;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_FILL_W = c_PTR_W + 1;

    localparam logic [DECIM_LOG2-1:0] c_PHASE_MAX = {DECIM_LOG2{1'b1}};
    localparam logic [DECIM_LOG2-1:0] c_PHASE_ONE = DECIM_LOG2'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_FILL_W-1:0]   c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [c_FILL_W-1:0]   c_DEPTH     = c_FILL_W'(FIFO_DEPTH);

    // Decimator state
    logic [DECIM_LOG2-1:0]      r_phase;
    logic signed [c_ACC_W-1:0]  r_acc;

    // FIFO state
    logic [DATA_W-1:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_FILL_W-1:0]        r_fill;
    logic                       r_overflow;

    logic signed [c_ACC_W-1:0]  w_in_ext;
    logic signed [c_ACC_W-1:0]  w_sum;
    logic signed [DATA_W-1:0]   w_avg;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_push_ok;

    // The accumulator is wide enough that the group sum never wraps; the
    // arithmetic shift floors toward -inf and the result always fits DATA_W.
    assign w_in_ext  = {{DECIM_LOG2{in_data[DATA_W-1]}}, in_data};
    assign w_sum     = r_acc + w_in_ext;
    assign w_avg     = DATA_W'(w_sum >>> DECIM_LOG2);

    assign w_push    = !reset && in_valid && (r_phase == c_PHASE_MAX);
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_ok = w_push && ((r_fill < c_DEPTH) || w_pop);

    assign out_valid = (r_fill != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fill      = r_fill;
    assign overflow  = r_overflow;

    // Phase counter and group accumulator; both hold while in_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else if (in_valid) begin
            r_phase <= r_phase + c_PHASE_ONE;
            r_acc   <= (r_phase == '0) ? w_in_ext : w_sum;
        end
    end

    // Storage array; contents need no reset since out_data is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_avg;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            unique case ({w_push_ok, w_pop})
                2'b10:   r_fill <= r_fill + c_FILL_ONE;
                2'b01:   r_fill <= r_fill - c_FILL_ONE;
                default: r_fill <= r_fill;
            endcase
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_decim_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_decim_fifo
// Purpose  : Self-checking bench for iir_decim_fifo: directed scenarios plus
//            randomized traffic compared against a queue-based group-average
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_decim_fifo;

    localparam int DATA_W     = 24;
    localparam int DECIM_LOG2 = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int GROUP_N    = 1 << DECIM_LOG2;
    localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1;

    logic                     clk;
    logic                     reset;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [FILL_W-1:0]        fill;
    logic                     overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: samples of the group in progress, FIFO contents, flag.
    int                       m_grp[$];
    logic signed [DATA_W-1:0] m_fifo[$];
    bit                       m_ovf;

    iir_decim_fifo #(
        .DATA_W     (DATA_W),
        .DECIM_LOG2 (DECIM_LOG2),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mathematical floor of s / n for positive n.
    function automatic int floor_div(input longint s, input int n);
        if (s >= 0) return int'(s / n);
        return int'(-((-s + n - 1) / n));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input int exp);
        logic [31:0] e;
        e = {8'h00, exp[DATA_W-1:0]};
        chk(tag, {8'h00, out_data}, e);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit   pop;
        bit   push;
        int   avg;
        longint sum;
        if (reset) begin
            m_grp.delete();
            m_fifo.delete();
            m_ovf = 1'b0;
            return;
        end
        pop  = (m_fifo.size() > 0) && out_ready;
        push = 1'b0;
        avg  = 0;
        if (in_valid) begin
            m_grp.push_back(int'(in_data));
            if (m_grp.size() == GROUP_N) begin
                sum = 0;
                foreach (m_grp[k]) sum += longint'(m_grp[k]);
                avg  = floor_div(sum, GROUP_N);
                push = 1'b1;
                m_grp.delete();
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(DATA_W'(avg));
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_d;
        exp_d = (m_fifo.size() > 0) ? {8'h00, m_fifo[0]} : 32'h0;
        chk("model_out_valid", {31'h0, out_valid}, {31'h0, m_fifo.size() > 0});
        chk("model_out_data", {8'h00, out_data}, exp_d);
        chk("model_fill", {28'h0, fill}, 32'(m_fifo.size()));
        chk("model_overflow", {31'h0, overflow}, {31'h0, m_ovf});
    endtask

    task automatic cycle(input logic v, input logic signed [DATA_W-1:0] d,
                         input logic rdy, input logic rs);
        reset     = rs;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    function automatic logic signed [DATA_W-1:0] rnd_sample();
        unique case ($urandom_range(0, 7))
            0:       return 24'sh7FFFFF;
            1:       return 24'sh800000;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_ovf     = 1'b0;

        // Reset with in_valid asserted must be ignored.
        cycle(1'b1, 24'sd55, 1'b1, 1'b1);
        cycle(1'b1, 24'sd77, 1'b1, 1'b1);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_fill", {28'h0, fill}, 32'h0);
        chk_data("reset_out_data", 0);
        chk("reset_overflow", {31'h0, overflow}, 32'h0);

        // Constant 1000: first output after the 4th sample, fill never above 1.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 24'sd1000, 1'b1, 1'b0);
            chk("const_fill_le1", {31'h0, fill <= 1}, 32'h1);
            if (i == 2) chk("const_no_early_out", {31'h0, out_valid}, 32'h0);
            if (i == 3) begin
                chk("const_first_valid", {31'h0, out_valid}, 32'h1);
                chk_data("const_first_data", 1000);
            end
        end

        // Floor rounding groups.
        cycle(1'b1, 24'sd0, 1'b1, 1'b0);
        cycle(1'b1, 24'sd1, 1'b1, 1'b0);
        cycle(1'b1, 24'sd2, 1'b1, 1'b0);
        cycle(1'b1, 24'sd3, 1'b1, 1'b0);
        chk_data("floor_0123", 1);
        cycle(1'b1, -24'sd1, 1'b1, 1'b0);
        cycle(1'b1, -24'sd1, 1'b1, 1'b0);
        cycle(1'b1, -24'sd1, 1'b1, 1'b0);
        cycle(1'b1, -24'sd2, 1'b1, 1'b0);
        chk_data("floor_neg", -2);
        for (int i = 0; i < 4; i++) cycle(1'b1, 24'sh7FFFFF, 1'b1, 1'b0);
        chk_data("floor_max", 8388607);
        for (int i = 0; i < 4; i++) cycle(1'b1, 24'sh800000, 1'b1, 1'b0);
        chk_data("floor_min", -8388608);

        // Gapped input: 4,x,x,8,12,x,16 -> 10.
        cycle(1'b1, 24'sd4, 1'b1, 1'b0);
        cycle(1'b0, rnd_sample(), 1'b1, 1'b0);
        cycle(1'b0, rnd_sample(), 1'b1, 1'b0);
        cycle(1'b1, 24'sd8, 1'b1, 1'b0);
        cycle(1'b1, 24'sd12, 1'b1, 1'b0);
        chk("gap_not_yet", {31'h0, out_valid}, 32'h0);
        cycle(1'b0, rnd_sample(), 1'b1, 1'b0);
        cycle(1'b1, 24'sd16, 1'b1, 1'b0);
        chk("gap_valid", {31'h0, out_valid}, 32'h1);
        chk_data("gap_data", 10);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: 8 groups fill the FIFO, the 9th is dropped.
        for (int g = 0; g < 9; g++) begin
            for (int i = 0; i < GROUP_N; i++) cycle(1'b1, rnd_sample(), 1'b0, 1'b0);
            if (g == 7) begin
                chk("bp_fill8", {28'h0, fill}, 32'd8);
                chk("bp_no_ovf_yet", {31'h0, overflow}, 32'h0);
            end
        end
        chk("bp_fill_still8", {28'h0, fill}, 32'd8);
        chk("bp_overflow", {31'h0, overflow}, 32'h1);
        for (int i = 0; i < FIFO_DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_drained", {28'h0, fill}, 32'h0);
        chk("bp_ovf_sticky", {31'h0, overflow}, 32'h1);

        // Full FIFO with pop and push in the same cycle.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8 * GROUP_N + 3; i++) cycle(1'b1, rnd_sample(), 1'b0, 1'b0);
        chk("full_fill8", {28'h0, fill}, 32'd8);
        cycle(1'b1, rnd_sample(), 1'b1, 1'b0);
        chk("simul_fill8", {28'h0, fill}, 32'd8);
        chk("simul_no_ovf", {31'h0, overflow}, 32'h0);

        // Reset mid-group with a non-empty FIFO.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3 * GROUP_N + 2; i++) cycle(1'b1, rnd_sample(), 1'b0, 1'b0);
        chk("pre_rst_fill3", {28'h0, fill}, 32'd3);
        cycle(1'b1, rnd_sample(), 1'b0, 1'b1);
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_fill", {28'h0, fill}, 32'h0);
        chk_data("mid_rst_data", 0);
        chk("mid_rst_ovf", {31'h0, overflow}, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 24'sd20, 1'b1, 1'b0);
        chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
        chk_data("post_rst_data", 20);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_single", {31'h0, out_valid}, 32'h0);

        // Randomized traffic with varying consumer readiness.
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 120; i++) begin
                logic v, r, rs;
                v  = ($urandom_range(0, 3) != 0);
                r  = ($urandom_range(0, 3) < seg);
                rs = ($urandom_range(0, 149) == 0);
                cycle(v, rnd_sample(), r, rs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
